alu_issue_ctrl: RTL and testbench

- Execute-stage initiator for the ALU: accepts one decoded instruction at a time over a valid/ready handshake.
- Translates funct3/funct7 into an ALU opcode and drives the ALU operands, holding them stable while the ALU's registered `illegal_op` flag settles.
- Returns either a write-back result or a branch decision (BEQ/BNE) over a second valid/ready handshake.
- Sits between decode/register-read and the write-back stage; it is the only driver of the ALU's `alu_op`, `r1` and `r2` inputs.

---
 rtl/alu_issue_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Execute-stage initiator for an external ALU. Accepts one decoded
//   RISC-V instruction at a time, converts funct3/funct7 into an ALU opcode,
//   drives the ALU operands for two cycles (ISSUE, then CHECK, so the ALU's
//   registered illegal_op flag belongs to this instruction) and returns a
//   write-back result or a BEQ/BNE decision over a valid/ready handshake.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : instruction handshake (in_ready only in IDLE)
//   in_funct3/7       : RISC-V funct fields
//   in_is_imm         : operand 2 comes from in_imm (OP-IMM)
//   in_is_branch      : branch compare, never writes back
//   in_rs1/rs2/imm/rd : operand values and destination register
//   alu_op/r1/r2      : ALU drive (ADD / 0 / 0 outside ISSUE and CHECK)
//   alu_res/alu_zero  : combinational ALU result and zero flag
//   alu_illegal       : ALU illegal_op, registered one cycle after alu_op
//   out_valid/ready   : response handshake
//   out_rd/data/wb    : write-back destination, data, enable
//   out_br_taken      : branch decision
//   out_exc           : illegal or unsupported operation
//
// Build option
//   MULDIV_EN : decode RV32M MUL/DIV/DIVU/REM/REMU (ALU must have RV32M too).
//               Without it, funct7=0000001 R-type instructions are unsupported.
//
// Opcode encoding (matches aluops.vh):
//   ADD=0 SUB=1 LSHIFT=2 XOR=3 LRSHIFT=4 ARSHIFT=5 OR=6 AND=7
//   MUL=8 DIV=9 DIVU=10 REM=11 REMU=12
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [6:0]      in_funct7,
  input  logic            in_is_imm,
  input  logic            in_is_branch,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_r1,
  output logic [XLEN-1:0] alu_r2,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  input  logic            alu_illegal,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  output logic            out_wb,
  output logic            out_br_taken,
  output logic            out_exc
);

  localparam logic [OPW-1:0] OP_ADD     = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB     = OPW'(1);
  localparam logic [OPW-1:0] OP_LSHIFT  = OPW'(2);
  localparam logic [OPW-1:0] OP_XOR     = OPW'(3);
  localparam logic [OPW-1:0] OP_LRSHIFT = OPW'(4);
  localparam logic [OPW-1:0] OP_ARSHIFT = OPW'(5);
  localparam logic [OPW-1:0] OP_OR      = OPW'(6);
  localparam logic [OPW-1:0] OP_AND     = OPW'(7);
`ifdef MULDIV_EN
  localparam logic [OPW-1:0] OP_MUL     = OPW'(8);
  localparam logic [OPW-1:0] OP_DIV     = OPW'(9);
  localparam logic [OPW-1:0] OP_DIVU    = OPW'(10);
  localparam logic [OPW-1:0] OP_REM     = OPW'(11);
  localparam logic [OPW-1:0] OP_REMU    = OPW'(12);
`endif

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, RESP} state_t;

  state_t          r_state;
  state_t          w_state_next;

  // Latched instruction
  logic [OPW-1:0]  r_op;
  logic [XLEN-1:0] r_r1;
  logic [XLEN-1:0] r_r2;
  logic            r_unsup;
  logic            r_is_branch;
  logic            r_br_ne;
  logic            r_zero;

  // Response registers
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_data;
  logic            r_wb;
  logic            r_br_taken;
  logic            r_exc;

  // Decode of the incoming instruction
  logic [OPW-1:0]  w_op;
  logic            w_unsup;
  logic            w_br_ne;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_r2;
  logic            w_exc;

  always_comb begin
    w_op    = OP_ADD;
    w_unsup = 1'b0;
    w_br_ne = 1'b0;
    if (in_is_branch) begin
      // Every branch computes rs1 - op2 so out_data carries the difference.
      w_op = OP_SUB;
      case (in_funct3)
        3'b000:  w_br_ne = 1'b0;
        3'b001:  w_br_ne = 1'b1;
        default: w_unsup = 1'b1;
      endcase
    end else if (!in_is_imm && in_funct7 == 7'b0000001) begin
`ifdef MULDIV_EN
      case (in_funct3)
        3'b000:  w_op = OP_MUL;
        3'b100:  w_op = OP_DIV;
        3'b101:  w_op = OP_DIVU;
        3'b110:  w_op = OP_REM;
        3'b111:  w_op = OP_REMU;
        default: w_unsup = 1'b1;   // MULH variants
      endcase
`else
      w_unsup = 1'b1;
`endif
    end else begin
      case (in_funct3)
        3'b000:  w_op = (!in_is_imm && in_funct7[5]) ? OP_SUB : OP_ADD;
        3'b001:  w_op = OP_LSHIFT;
        3'b100:  w_op = OP_XOR;
        3'b101:  w_op = in_funct7[5] ? OP_ARSHIFT : OP_LRSHIFT;
        3'b110:  w_op = OP_OR;
        3'b111:  w_op = OP_AND;
        default: w_unsup = 1'b1;   // SLT / SLTU
      endcase
    end
  end

  assign w_op2 = in_is_imm ? in_imm : in_rs2;
  // Shift amounts are masked so OP-IMM encodings with funct7 bits in the
  // immediate never leak into the ALU's shift distance.
  assign w_r2  = (w_op == OP_LSHIFT || w_op == OP_LRSHIFT || w_op == OP_ARSHIFT)
               ? {{(XLEN-5){1'b0}}, w_op2[4:0]} : w_op2;
  assign w_exc = alu_illegal | r_unsup;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake / ALU drive
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    alu_op       = OP_ADD;
    alu_r1       = '0;
    alu_r2       = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ISSUE;
      end
      ISSUE: begin
        alu_op       = r_op;
        alu_r1       = r_r1;
        alu_r2       = r_r2;
        w_state_next = CHECK;
      end
      CHECK: begin
        // Operands held so the registered alu_illegal matches this op.
        alu_op       = r_op;
        alu_r1       = r_r1;
        alu_r2       = r_r2;
        w_state_next = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_ADD;
      r_r1        <= '0;
      r_r2        <= '0;
      r_unsup     <= 1'b0;
      r_is_branch <= 1'b0;
      r_br_ne     <= 1'b0;
      r_zero      <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_wb        <= 1'b0;
      r_br_taken  <= 1'b0;
      r_exc       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op        <= w_op;
            r_r1        <= in_rs1;
            r_r2        <= w_r2;
            r_unsup     <= w_unsup;
            r_is_branch <= in_is_branch;
            r_br_ne     <= w_br_ne;
            r_rd        <= in_rd;
          end
        end
        ISSUE: begin
          r_data <= alu_res;
          r_zero <= alu_zero;
        end
        CHECK: begin
          r_exc      <= w_exc;
          r_wb       <= !w_exc && !r_is_branch;
          r_br_taken <= !w_exc && r_is_branch && (r_br_ne ? !r_zero : r_zero);
        end
        default: ;
      endcase
    end
  end

  assign out_rd       = r_rd;
  assign out_data     = r_data;
  assign out_wb       = r_wb;
  assign out_br_taken = r_br_taken;
  assign out_exc      = r_exc;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl. Contains a simple ALU (combinational result,
//   registered illegal flag), a transaction-level reference model that
//   derives the expected ALU drive and response from the instruction fields,
//   a per-cycle compare process, directed cases with literal expectations,
//   and a randomized phase with random backpressure and ignored in_valid
//   traffic. Honours MULDIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam logic [4:0] A_ADD = 5'd0,  A_SUB = 5'd1,  A_SLL = 5'd2,  A_XOR = 5'd3;
  localparam logic [4:0] A_SRL = 5'd4,  A_SRA = 5'd5,  A_OR  = 5'd6,  A_AND = 5'd7;
  localparam logic [4:0] A_MUL = 5'd8,  A_DIV = 5'd9,  A_DIVU = 5'd10;
  localparam logic [4:0] A_REM = 5'd11, A_REMU = 5'd12;

  logic        clk, rst;
  logic        in_valid, in_ready, in_is_imm, in_is_branch;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic [4:0]  alu_op;
  logic [31:0] alu_r1, alu_r2, alu_res;
  logic        alu_zero, alu_illegal;
  logic        out_valid, out_ready, out_wb, out_br_taken, out_exc;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_is_imm(in_is_imm), .in_is_branch(in_is_branch),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .alu_op(alu_op), .alu_r1(alu_r1), .alu_r2(alu_r2),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_illegal(alu_illegal),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_data(out_data), .out_wb(out_wb),
    .out_br_taken(out_br_taken), .out_exc(out_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU stand-in ----------------
  function automatic logic [31:0] div_s(input logic [31:0] a, input logic [31:0] b, input bit rem);
    logic [31:0] r;
    if (b == 32'd0)                               r = rem ? a : 32'hFFFF_FFFF;
    else if (a == 32'h8000_0000 && b == '1)      r = rem ? 32'd0 : a;
    else if (rem)                                 r = $signed(a) % $signed(b);
    else                                          r = $signed(a) / $signed(b);
    return r;
  endfunction

  function automatic logic [31:0] div_u(input logic [31:0] a, input logic [31:0] b, input bit rem);
    logic [31:0] r;
    if (b == 32'd0) r = rem ? a : 32'hFFFF_FFFF;
    else if (rem)   r = a % b;
    else            r = a / b;
    return r;
  endfunction

  always_comb begin
    alu_res = '0;
    case (alu_op)
      A_ADD:   alu_res = alu_r1 + alu_r2;
      A_SUB:   alu_res = alu_r1 - alu_r2;
      A_SLL:   alu_res = alu_r1 << alu_r2[4:0];
      A_XOR:   alu_res = alu_r1 ^ alu_r2;
      A_SRL:   alu_res = alu_r1 >> alu_r2[4:0];
      A_SRA:   alu_res = 32'($signed(alu_r1) >>> alu_r2[4:0]);
      A_OR:    alu_res = alu_r1 | alu_r2;
      A_AND:   alu_res = alu_r1 & alu_r2;
      A_MUL:   alu_res = alu_r1 * alu_r2;
      A_DIV:   alu_res = div_s(alu_r1, alu_r2, 1'b0);
      A_DIVU:  alu_res = div_u(alu_r1, alu_r2, 1'b0);
      A_REM:   alu_res = div_s(alu_r1, alu_r2, 1'b1);
      A_REMU:  alu_res = div_u(alu_r1, alu_r2, 1'b1);
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == 32'd0);

  always @(posedge clk)
    alu_illegal <= (alu_op > A_REMU) || (alu_op >= A_DIV && alu_op <= A_REMU && alu_r2 == 32'd0);

  // ---------------- checking infrastructure ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  op;
    logic [31:0] r1, r2, data;
    logic [4:0]  rd;
    logic        wb, br, exc;
  } exp_t;

  // What an instruction means architecturally, and thus what the ALU must
  // see and what the response must contain.
  function automatic exp_t model(input logic [2:0] f3, input logic [6:0] f7, input logic ii,
                                 input logic ib, input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [31:0] im, input logic [4:0] rd);
    exp_t e;
    logic [31:0] b;
    bit unsup, taken, bad;
    b = ii ? im : rs2;
    unsup = 0; taken = 0; bad = 0;
    e.r1 = a; e.r2 = b; e.rd = rd;
    e.op = A_ADD; e.data = a + b;
    if (ib) begin
      e.op = A_SUB; e.data = a - b;
      if (f3 == 3'd0)      taken = (a == b);
      else if (f3 == 3'd1) taken = (a != b);
      else                 unsup = 1;
    end else if (!ii && f7 == 7'd1) begin
`ifdef MULDIV_EN
      case (f3)
        3'd0: begin e.op = A_MUL;  e.data = a * b; end
        3'd4: begin e.op = A_DIV;  e.data = div_s(a, b, 1'b0); bad = (b == 0); end
        3'd5: begin e.op = A_DIVU; e.data = div_u(a, b, 1'b0); bad = (b == 0); end
        3'd6: begin e.op = A_REM;  e.data = div_s(a, b, 1'b1); bad = (b == 0); end
        3'd7: begin e.op = A_REMU; e.data = div_u(a, b, 1'b1); bad = (b == 0); end
        default: unsup = 1;
      endcase
`else
      unsup = 1;
`endif
    end else begin
      case (f3)
        3'd0: if (!ii && f7[5]) begin e.op = A_SUB; e.data = a - b; end
        3'd1: begin e.op = A_SLL; e.r2 = {27'd0, b[4:0]}; e.data = a << b[4:0]; end
        3'd4: begin e.op = A_XOR; e.data = a ^ b; end
        3'd5: begin
          e.r2 = {27'd0, b[4:0]};
          if (f7[5]) begin e.op = A_SRA; e.data = 32'($signed(a) >>> b[4:0]); end
          else       begin e.op = A_SRL; e.data = a >> b[4:0]; end
        end
        3'd6: begin e.op = A_OR;  e.data = a | b; end
        3'd7: begin e.op = A_AND; e.data = a & b; end
        default: unsup = 1;
      endcase
    end
    e.exc = unsup || bad;
    e.wb  = !e.exc && !ib;
    e.br  = !e.exc && taken;
    return e;
  endfunction

  // Model timeline: m_age counts cycles since the accepting edge.
  bit   m_busy = 1'b0;
  int   m_age  = 0;
  exp_t m_exp;

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("in_ready", in_ready, !m_busy);
      chk1("out_valid", out_valid, m_busy && m_age >= 3);
      if (m_busy && (m_age == 1 || m_age == 2)) begin
        chk("alu_op", 32'(alu_op), 32'(m_exp.op));
        chk("alu_r1", alu_r1, m_exp.r1);
        chk("alu_r2", alu_r2, m_exp.r2);
      end else begin
        chk("alu_op_idle", 32'(alu_op), 32'(A_ADD));
        chk("alu_r1_idle", alu_r1, 32'd0);
        chk("alu_r2_idle", alu_r2, 32'd0);
      end
      if (m_busy && m_age >= 3) begin
        chk("out_data", out_data, m_exp.data);
        chk("out_rd", 32'(out_rd), 32'(m_exp.rd));
        chk1("out_wb", out_wb, m_exp.wb);
        chk1("out_br_taken", out_br_taken, m_exp.br);
        chk1("out_exc", out_exc, m_exp.exc);
      end
    end
    // Advance to the state after the coming edge.
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_exp  = model(in_funct3, in_funct7, in_is_imm, in_is_branch, in_rs1, in_rs2, in_imm, in_rd);
      end
    end else if (m_age >= 3 && out_ready) begin
      m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic [2:0] f3, input logic [6:0] f7, input logic ii, input logic ib,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [4:0] rd);
    in_funct3 = f3; in_funct7 = f7; in_is_imm = ii; in_is_branch = ib;
    in_rs1 = a; in_rs2 = b; in_imm = im; in_rd = rd;
  endtask

  task automatic rand_fields();
    logic [6:0] f7;
    logic ib;
    case ($urandom_range(0, 3))
      0:       f7 = 7'h00;
      1:       f7 = 7'h20;
      2:       f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    ib = ($urandom_range(0, 3) == 0);
    set_in(3'($urandom), f7, !ib && ($urandom_range(0, 2) == 0), ib, $urandom,
           $urandom, $urandom, 5'($urandom));
    if ($urandom_range(0, 3) == 0) in_rs2 = in_rs1;
    if ($urandom_range(0, 7) == 0) in_rs2 = 32'd0;
    if ($urandom_range(0, 3) == 0) in_imm = 32'($urandom_range(0, 63));
  endtask

  // Present the current fields and wait for acceptance; returns #1 after
  // the accepting edge.
  task automatic issue();
    bit acc;
    bit done;
    done = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) done = 1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: got no in_ready expected acceptance");
    end
  endtask

  // Wait for the response, hold off `delay` cycles, then accept it.
  task automatic collect(input int delay, input bit junk,
                         output logic [31:0] d, output logic [4:0] r,
                         output logic w, output logic t, output logic x, output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (junk) begin rand_fields(); in_valid = 1'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
    for (int i = 0; i < delay; i++) begin
      if (junk) begin rand_fields(); in_valid = 1'($urandom); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    d = out_data; r = out_rd; w = out_wb; t = out_br_taken; x = out_exc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] d;
  logic [4:0]  r;
  logic        w, t, x;
  int          lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_in(3'd0, 7'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk1("rst_out_wb", out_wb, 1'b0);
    chk1("rst_out_br", out_br_taken, 1'b0);
    chk1("rst_out_exc", out_exc, 1'b0);

    // ADD 5 + 7 -> x3
    set_in(3'd0, 7'h00, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk("add_latency", 32'(lat), 32'd3);
    chk("add_data", d, 32'd12);
    chk("add_rd", 32'(r), 32'd3);
    chk1("add_wb", w, 1'b1);
    chk1("add_exc", x, 1'b0);

    // SRAI 0x80000000 >>> 4
    set_in(3'd5, 7'h20, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 32'h0000_0404, 5'd9);
    issue();
    chk("srai_alu_r2", alu_r2, 32'd4);
    chk("srai_alu_op", 32'(alu_op), 32'(A_SRA));
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk("srai_data", d, 32'hF800_0000);

    // BEQ / BNE with equal operands
    set_in(3'd0, 7'h00, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 5'd1);
    issue();
    collect(1, 1'b0, d, r, w, t, x, lat);
    chk1("beq_taken", t, 1'b1);
    chk1("beq_wb", w, 1'b0);
    set_in(3'd1, 7'h00, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 5'd1);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk1("bne_taken", t, 1'b0);
    chk1("bne_wb", w, 1'b0);

    // SLT is unsupported
    set_in(3'd2, 7'h00, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd4);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk1("slt_exc", x, 1'b1);
    chk1("slt_wb", w, 1'b0);

    // Backpressure: response held for 5 cycles
    set_in(3'd7, 7'h00, 1'b0, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 5'd12);
    issue();
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    d = out_data; r = out_rd; w = out_wb;
    chk("bp_data", d, 32'h0F00_0F00);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid_held", out_valid, 1'b1);
      chk1("bp_in_ready", in_ready, 1'b0);
      chk("bp_data_stable", out_data, d);
      chk("bp_rd_stable", 32'(out_rd), 32'(r));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk1("bp_in_ready_after", in_ready, 1'b1);
    chk1("bp_valid_after", out_valid, 1'b0);

    // Reset during CHECK drops the instruction
    set_in(3'd4, 7'h00, 1'b0, 1'b0, 32'hF0, 32'hFF, 32'd0, 5'd7);
    issue();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk1("rstmid_valid", out_valid, 1'b0);
    chk1("rstmid_ready", in_ready, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
      chk1("rstmid_no_resp", out_valid, 1'b0);
    end
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk("xor_data", d, 32'h0F);
    chk("xor_rd", 32'(r), 32'd7);

`ifdef MULDIV_EN
    set_in(3'd4, 7'h01, 1'b0, 1'b0, 32'd10, 32'd0, 32'd0, 5'd5);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk1("div0_exc", x, 1'b1);
    chk1("div0_wb", w, 1'b0);
    set_in(3'd0, 7'h01, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 5'd6);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk("mul_data", d, 32'd42);
    chk1("mul_exc", x, 1'b0);
`else
    set_in(3'd0, 7'h01, 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 5'd6);
    issue();
    collect(0, 1'b0, d, r, w, t, x, lat);
    chk1("mul_off_exc", x, 1'b1);
    chk1("mul_off_wb", w, 1'b0);
`endif

    // Randomized traffic, checked every cycle by the compare process
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      rand_fields();
      issue();
      collect($urandom_range(0, 3), 1'b1, d, r, w, t, x, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
